// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex-measurement sequencer.
package reflex_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GO,
    S_DONE
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/reflex_ctrl_lfsr8.sv
// 8-bit free-running Fibonacci LFSR; seed is non-zero so the state never locks up.
module lfsr8
  import reflex_pkg::*;
(
  input  logic       ck,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

endmodule

// File: rtl/reflex_ctrl.sv
// Reflex round sequencer: random delay via external ds timer, then ms reaction count.
// Optional BEST_SCORE_EN adds a best-result tracker (best_ms/best_valid).
module reflex_ctrl
  import reflex_pkg::*;
#(
  parameter int MIN_DS   = 10,
  parameter int RANGE_DS = 32,
  parameter int MAX_MS   = 9999,
  parameter int RES_W    = 14
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             tick_ms,
  input  logic             tmr_zero,
  output logic             tmr_load,
  output logic [5:0]       tmr_value,
  output logic             led_go,
  output logic             busy,
  output logic [RES_W-1:0] result_ms,
  output logic             result_valid,
  output logic             false_start,
  output logic             timeout
`ifdef BEST_SCORE_EN
  ,
  output logic [RES_W-1:0] best_ms,
  output logic             best_valid
`endif
);

  localparam int RW = $clog2(RANGE_DS);

  state_t           state;
  logic [7:0]       lfsr;
  logic             start_q, stop_q;
  logic             start_press, stop_press;
  logic [RES_W-1:0] cnt;
  logic             unused_lfsr;

  lfsr8 u_lfsr (.ck(ck), .reset(reset), .q(lfsr));

  assign unused_lfsr = ^lfsr;
  assign start_press = start & ~start_q;
  assign stop_press  = stop & ~stop_q;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      tmr_load     <= 1'b0;
      tmr_value    <= '0;
      led_go       <= 1'b0;
      busy         <= 1'b0;
      cnt          <= '0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_press) begin
            state        <= S_ARM;
            busy         <= 1'b1;
            tmr_load     <= 1'b1;
            tmr_value    <= 6'(MIN_DS) + 6'(lfsr[RW-1:0]);
            result_ms    <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
          end
        end
        S_ARM: begin
          tmr_load <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A press while the timer expires still counts as jumping the gun
          if (stop_press) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            false_start <= 1'b1;
          end else if (tmr_zero) begin
            state  <= S_GO;
            led_go <= 1'b1;
            cnt    <= '0;
          end
        end
        S_GO: begin
          if (stop_press) begin
            state        <= S_DONE;
            busy         <= 1'b0;
            led_go       <= 1'b0;
            result_ms    <= cnt;
            result_valid <= 1'b1;
          end else if (tick_ms) begin
            if (cnt == RES_W'(MAX_MS)) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              led_go    <= 1'b0;
              result_ms <= RES_W'(MAX_MS);
              timeout   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BEST_SCORE_EN
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      best_ms    <= '0;
      best_valid <= 1'b0;
    end else if (state == S_GO && stop_press) begin
      if (!best_valid || cnt < best_ms) best_ms <= cnt;
      best_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reflex_ctrl.sv
// Directed bench for reflex_ctrl with a small behavioural ds countdown timer.
module tb_reflex_ctrl;

  localparam int RES_W = 14;

  logic             ck = 1'b0;
  logic             reset, start, stop, tick_ms;
  logic             tmr_zero, tmr_load, led_go, busy;
  logic [5:0]       tmr_value;
  logic [RES_W-1:0] result_ms;
  logic             result_valid, false_start, timeout;
`ifdef BEST_SCORE_EN
  logic [RES_W-1:0] best_ms;
  logic             best_valid;
`endif

  int checks = 0;
  int errors = 0;

  reflex_ctrl #(.MIN_DS(10), .RANGE_DS(32), .MAX_MS(9999), .RES_W(RES_W)) dut (
    .ck(ck), .reset(reset), .start(start), .stop(stop), .tick_ms(tick_ms),
    .tmr_zero(tmr_zero), .tmr_load(tmr_load), .tmr_value(tmr_value),
    .led_go(led_go), .busy(busy), .result_ms(result_ms),
    .result_valid(result_valid), .false_start(false_start), .timeout(timeout)
`ifdef BEST_SCORE_EN
    , .best_ms(best_ms), .best_valid(best_valid)
`endif
  );

  always #5 ck = ~ck;

  // Countdown timer stand-in (shrunk: decrements every clock)
  logic [5:0] tb_tmr;
  always_ff @(posedge ck or posedge reset) begin
    if (reset)             tb_tmr <= '0;
    else if (tmr_load)     tb_tmr <= tmr_value;
    else if (tb_tmr != 0)  tb_tmr <= tb_tmr - 1'b1;
  end
  assign tmr_zero = (tb_tmr == 0);

  // Reference LFSR; m_prev holds the value the DUT used at the last edge
  logic [7:0] m_lfsr, m_prev;
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_ms = 1'b1; @(negedge ck);
      tick_ms = 1'b0; @(negedge ck);
    end
  endtask

  task automatic start_round();
    start = 1'b1; @(negedge ck);
    start = 1'b0; @(negedge ck);
  endtask

  task automatic wait_tz();
    int n = 0;
    while (tb_tmr != 0 && n < 200) begin
      @(negedge ck);
      n++;
    end
    chk("wait_timer_expiry", 32'(tb_tmr == 0), 1);
  endtask

  task automatic play(input int n, input string tag);
    start_round();
    wait_tz();
    @(negedge ck);
    tick_n(n);
    stop = 1'b1; @(negedge ck); stop = 1'b0;
    chk(tag, 32'(result_ms), 32'(n));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; tick_ms = 1'b0;
    repeat (3) @(negedge ck);
    chk("rst_tmr_load", 32'(tmr_load), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_led_go", 32'(led_go), 0);
    chk("rst_result_ms", 32'(result_ms), 0);
    chk("rst_flags", 32'({result_valid, false_start, timeout}), 0);
    reset = 1'b0;
    @(negedge ck);

    // 1/2: normal round, 250 ms reaction
    start = 1'b1; @(negedge ck);
    chk("arm_tmr_load", 32'(tmr_load), 1);
    chk("arm_busy", 32'(busy), 1);
    chk("arm_tmr_value", 32'(tmr_value), 32'(10 + m_prev[4:0]));
    chk("arm_value_range", 32'(tmr_value >= 10 && tmr_value <= 41), 1);
    start = 1'b0; @(negedge ck);
    chk("load_one_cycle", 32'(tmr_load), 0);
    chk("wait_led_off", 32'(led_go), 0);
    wait_tz();
    @(negedge ck);
    chk("go_led_on", 32'(led_go), 1);
    tick_n(250);
    stop = 1'b1; @(negedge ck); stop = 1'b0;
    chk("r250_result_ms", 32'(result_ms), 250);
    chk("r250_valid", 32'({result_valid, false_start, timeout}), 3'b100);
    chk("r250_led_off", 32'(led_go), 0);
    chk("r250_busy_off", 32'(busy), 0);

    // 3: stop during WAIT
    start_round();
    chk("arm_clears_valid", 32'(result_valid), 0);
    chk("arm_clears_ms", 32'(result_ms), 0);
    stop = 1'b1; @(negedge ck); stop = 1'b0;
    chk("fs_flags", 32'({result_valid, false_start, timeout}), 3'b010);
    chk("fs_result_ms", 32'(result_ms), 0);
    chk("fs_led_off", 32'(led_go), 0);
    repeat (50) @(negedge ck);
    chk("fs_led_never", 32'(led_go), 0);

    // 4: timeout at MAX_MS
    start_round();
    wait_tz();
    @(negedge ck);
    tick_n(9999);
    chk("to_not_yet", 32'({timeout, led_go}), 2'b01);
    tick_n(1);
    chk("to_flags", 32'({result_valid, false_start, timeout}), 3'b001);
    chk("to_result_ms", 32'(result_ms), 9999);
    chk("to_led_off", 32'(led_go), 0);

    // 5a: stop and tick together at counter 7
    start_round();
    wait_tz();
    @(negedge ck);
    tick_n(7);
    stop = 1'b1; tick_ms = 1'b1; @(negedge ck); stop = 1'b0; tick_ms = 1'b0;
    chk("st_same_ms", 32'(result_ms), 7);
    chk("st_same_valid", 32'(result_valid), 1);

    // 5b: stop and tmr_zero together
    start_round();
    wait_tz();
    stop = 1'b1; @(negedge ck); stop = 1'b0;
    chk("sz_false_start", 32'(false_start), 1);
    chk("sz_led_off", 32'(led_go), 0);

    // 6: reset mid-GO
    start_round();
    wait_tz();
    @(negedge ck);
    tick_n(3);
    chk("pre_rst_go", 32'(led_go), 1);
    reset = 1'b1; #1;
    chk("midrst_async", 32'({led_go, busy, tmr_load}), 0);
    @(negedge ck);
    chk("midrst_outputs", 32'({led_go, busy, tmr_load, result_valid, false_start, timeout}), 0);
    chk("midrst_ms", 32'(result_ms), 0);
    reset = 1'b0; @(negedge ck);
    start = 1'b1; @(negedge ck); start = 1'b0;
    chk("post_rst_arm", 32'(tmr_load), 1);
    @(negedge ck);
    stop = 1'b1; @(negedge ck); stop = 1'b0;

`ifdef BEST_SCORE_EN
    reset = 1'b1; @(negedge ck);
    chk("best_rst", 32'({best_valid, best_ms}), 0);
    reset = 1'b0; @(negedge ck);
    play(300, "best_r300");
    chk("best_first", 32'(best_ms), 300);
    play(200, "best_r200");
    play(400, "best_r400");
    chk("best_min", 32'(best_ms), 200);
    chk("best_valid", 32'(best_valid), 1);
`else
    play(42, "plain_r42");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
